// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load clamp helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t value);
    return (value > BCD_MAX) ? BCD_MAX : value;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: clear > load (clamped to 9) > step up/down with 9<->0 rollover.
// Registered value, one cycle latency; at_max/at_min are combinational from the register.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       up,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_inc;
  bcd_digit_t digit_dec;

  assign at_max    = (digit == BCD_MAX);
  assign at_min    = (digit == BCD_MIN);
  assign digit_inc = at_max ? BCD_MIN : digit + 4'd1;
  assign digit_dec = at_min ? BCD_MAX : digit - 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= BCD_MIN;
    end else if (clear) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (step) begin
      digit <= up ? digit_inc : digit_dec;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// DIGITS-digit BCD up/down counter with clear, clamped load and cascade tc; q/load_err one cycle, tc combinational.
// Build option BCD_COUNTER_SATURATE_EN holds at all-9s/all-0s instead of wrapping; tc is unaffected.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   max_chain;
  logic [DIGITS:0]   min_chain;
  logic              sat_hold;
  logic              load_bad;

  assign max_chain[0] = 1'b1;
  assign min_chain[0] = 1'b1;

`ifdef BCD_COUNTER_SATURATE_EN
  // Freeze every digit when the step would wrap the whole counter.
  assign sat_hold = up ? max_chain[DIGITS] : min_chain[DIGITS];
`else
  assign sat_hold = 1'b0;
`endif

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign max_chain[i+1] = max_chain[i] & at_max[i];
      assign min_chain[i+1] = min_chain[i] & at_min[i];
      assign step[i] = enable & ~sat_hold & (up ? max_chain[i] : min_chain[i]);

      bcd_digit u_digit (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (step[i]),
        .up         (up),
        .clear      (clear),
        .load       (load),
        .load_digit (load_value[4*i +: 4]),
        .digit      (q[4*i +: 4]),
        .at_max     (at_max[i]),
        .at_min     (at_min[i])
      );
    end
  endgenerate

  assign tc = enable & (up ? max_chain[DIGITS] : min_chain[DIGITS]);

  always_comb begin
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > BCD_MAX) load_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= ~clear & load & load_bad;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (DIGITS=4) against an integer-valued reference model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        up;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] q;
  logic        tc;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counter value as a plain integer 0..9999
  int m_val = 0;
  bit m_err = 1'b0;

`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  bcd_updown_counter #(.DIGITS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .up         (up),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .q          (q),
    .tc         (tc),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic exp_tc();
    return enable && (up ? (m_val == 9999) : (m_val == 0));
  endfunction

  task automatic model_step();
    int dg;
    if (!reset_n) begin
      m_val = 0;
      m_err = 1'b0;
    end else if (clear) begin
      m_val = 0;
      m_err = 1'b0;
    end else if (load) begin
      m_val = 0;
      m_err = 1'b0;
      for (int d = 3; d >= 0; d--) begin
        dg = int'(load_value[4*d +: 4]);
        if (dg > 9) begin
          dg = 9;
          m_err = 1'b1;
        end
        m_val = m_val * 10 + dg;
      end
    end else begin
      m_err = 1'b0;
      if (enable) begin
        if (up) m_val = (SAT && m_val == 9999) ? 9999 : (m_val + 1) % 10000;
        else    m_val = (SAT && m_val == 0)    ? 0    : (m_val + 9999) % 10000;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic u, input logic clr,
                       input logic ld, input logic [15:0] lv);
    enable     = en;
    up         = u;
    clear      = clr;
    load       = ld;
    load_value = lv;
  endtask

  task automatic do_load(input logic [15:0] lv);
    drive(1'b0, 1'b1, 1'b0, 1'b1, lv);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    m_val = 0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (q !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_q: q=%h expected 0000", q);
    end
    n_tests++;
    if (load_err !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: load_err=%b tc=%b expected 0 0", load_err, tc);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_count_up();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 1234; i++) tick();
    n_tests++;
    if (q !== 16'h1234 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL count_1234: q=%h load_err=%b expected 1234 0", q, load_err);
    end
  endtask

  task automatic test_carry_borrow();
    do_load(16'h0999);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    n_tests++;
    if (q !== 16'h1000) begin
      n_fail++;
      $display("FAIL carry: q=%h expected 1000", q);
    end
    do_load(16'h1000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    n_tests++;
    if (q !== 16'h0999) begin
      n_fail++;
      $display("FAIL borrow: q=%h expected 0999", q);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_up;
    logic [15:0] exp_dn;
    exp_up = SAT ? 16'h9999 : 16'h0000;
    exp_dn = SAT ? 16'h0000 : 16'h9999;
    do_load(16'h9999);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    #1;
    n_tests++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL tc_up: tc=%b expected 1", tc);
    end
    tick();
    n_tests++;
    if (q !== exp_up) begin
      n_fail++;
      $display("FAIL wrap_up: q=%h expected %h", q, exp_up);
    end
    do_load(16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    n_tests++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL tc_down: tc=%b expected 1", tc);
    end
    tick();
    n_tests++;
    if (q !== exp_dn) begin
      n_fail++;
      $display("FAIL wrap_down: q=%h expected %h", q, exp_dn);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    n_tests++;
    if (tc !== 1'b0) begin
      n_fail++;
      $display("FAIL tc_disabled: tc=%b expected 0", tc);
    end
  endtask

  task automatic test_load_err();
    do_load(16'h3A7F);
    n_tests++;
    if (q !== 16'h3979 || load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL load_clamp: q=%h load_err=%b expected 3979 1", q, load_err);
    end
    tick();
    n_tests++;
    if (load_err !== 1'b0 || q !== 16'h3979) begin
      n_fail++;
      $display("FAIL load_err_pulse: q=%h load_err=%b expected 3979 0", q, load_err);
    end
    do_load(16'h1234);
    n_tests++;
    if (q !== 16'h1234 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_legal: q=%h load_err=%b expected 1234 0", q, load_err);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hB456);
    tick();
    n_tests++;
    if (q !== 16'h0000 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_over_load: q=%h load_err=%b expected 0000 0", q, load_err);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0777);
    tick();
    n_tests++;
    if (q !== 16'h0777) begin
      n_fail++;
      $display("FAIL load_over_enable: q=%h expected 0777", q);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    n_tests++;
    if (q !== 16'h0777) begin
      n_fail++;
      $display("FAIL hold: q=%h expected 0777", q);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 42; i++) tick();
    n_tests++;
    if (q !== 16'h0042) begin
      n_fail++;
      $display("FAIL pre_reset: q=%h expected 0042", q);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (q !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: q=%h expected 0000", q);
    end
    m_val = 0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (q !== 16'h0005) begin
      n_fail++;
      $display("FAIL resume: q=%h expected 0005", q);
    end
  endtask

  task automatic test_random();
    logic [15:0] lv;
    for (int i = 0; i < 1500; i++) begin
      lv = 16'($urandom);
      drive(($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0), lv);
      // Occasionally jump to the wrap boundaries
      if ($urandom_range(0, 40) == 0) begin
        load = 1'b1;
        load_value = $urandom_range(0, 1) ? 16'h9999 : 16'h0000;
      end
      #1;
      n_tests++;
      if (tc !== exp_tc()) begin
        n_fail++;
        $display("FAIL rand_tc[%0d]: tc=%b expected %b", i, tc, exp_tc());
      end
      tick();
      n_tests++;
      if (q !== to_bcd(m_val) || load_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_q[%0d]: q=%h load_err=%b expected %h %b",
                 i, q, load_err, to_bcd(m_val), m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_carry_borrow();
    test_wrap();
    test_load_err();
    test_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous clear, parallel load and cascade terminal-count output. It generalises the single-digit decade counter to DIGITS packed BCD digits and adds counting direction, preset and load validation. It sits in display, timer and event-tally paths, and can be chained through `tc` to build wider counters.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1..8.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  count enable; one step per cycle while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement.
- `clear`  input  1  synchronous clear to zero.
- `load`  input  1  synchronous parallel load.
- `load_value`  input  4*DIGITS  packed BCD preset; digit 0 at [3:0].
- `q`  output  4*DIGITS  packed BCD count; digit 0 (least significant) at [3:0].
- `tc`  output  1  terminal count, combinational (see Operation).
- `load_err`  output  1  registered; pulses high for one cycle after a load containing an illegal digit.

## Operation
- Reset: `q` = 0 and `load_err` = 0, applied asynchronously.
- Priority per cycle is clear > load > enable > hold.
- Clear: `q` becomes 0 and `load_err` becomes 0.
- Load: each digit of `load_value` is written to `q`. Any digit above 9 is written as 9 instead. `load_err` goes high for the next cycle if any digit was above 9; otherwise it is 0.
- Count up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. Digit i changes only when all lower digits are 9.
- Count down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. Digit i changes only when all lower digits are 0.
- Wrap: up from all-9s gives all-0s; down from all-0s gives all-9s.
- `tc` = `enable` & (`up` ? all digits == 9 : all digits == 0). It is not gated by clear or load.
- When `enable` is low, `q` holds. When `up` changes, the new direction applies on the next counted edge; there is no extra latency.
- `load_err` is 0 in every cycle that is not the cycle after an erroneous load.
- `q` never holds a digit above 9, from any reachable state.

## Timing
- `q` and `load_err` are registered; a change is visible one clk after the qualifying edge.
- `tc` is combinational from `q`, `up` and `enable`, with no registered stage. It goes high in the same cycle that the wrapping step is requested, so a downstream counter's `enable` can be tied to this block's `tc`.
- Reset asserted mid-count forces `q` = 0 immediately, independent of clk. Counting resumes at the first rising edge after `reset_n` deasserts with `enable` high.
- If clear and load are both high, clear wins and `load_err` stays 0.

## Configuration
- `BCD_COUNTER_SATURATE_EN`
- Defined:
  - Counting up at all-9s holds at all-9s.
  - Counting down at all-0s holds at all-0s.
  - `tc` is still asserted under its usual condition, so chaining remains possible.
- Undefined: wrap-around behaviour as in Operation.
- Load, clear and reset behaviour are identical in both builds.

## Structure
- Package `bcd_pkg` holds:
  - `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0.
  - typedef `bcd_digit_t` (logic [3:0]).
  - function `bcd_clamp` (value > 9 ? 9 : value).
- Sub-module `bcd_digit` implements one digit:
  - inputs: clk, reset_n, step, up, clear, load, load digit.
  - output: digit value.
  - combinational outputs: at_max, at_min.
- The top level instantiates DIGITS copies of `bcd_digit` in a generate loop. It forms each digit's step enable as `enable` AND the AND-chain of the lower digits' at_max (counting up) or at_min (counting down).
- The top level also builds `tc` and registers `load_err`.

## Test plan
- DIGITS=4, reset then `enable`=1, `up`=1 for 1234 cycles -> `q` = 16'h1234, `load_err` = 0.
- Load 16'h0999, `up`=1, `enable` for one cycle -> `q` = 16'h1000. Load 16'h1000, `up`=0, one step -> `q` = 16'h0999.
- Load 16'h9999, `up`=1, `enable`=1 -> `tc` = 1 in the same cycle, then `q` = 16'h0000 (16'h9999 with SATURATE_EN). Down from 16'h0000 -> 16'h9999 (held at 16'h0000 with SATURATE_EN), with `tc` = 1.
- Load 16'h3A7F -> `q` = 16'h3979 and `load_err` = 1 for exactly one cycle. Load 16'h1234 -> `load_err` = 0.
- Load and clear together with `enable` high -> `q` = 0. Load and `enable` together -> load value wins with no count step.
- Count to 16'h0042, assert `reset_n` low mid-cycle -> `q` = 0 before the next edge. After release, 5 enabled edges -> `q` = 16'h0005.
